fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 46 ++++
 rtl/fq_fifo.sv | 68 ++++++
 rtl/fetch_queue.sv | 122 ++++++++++++
 tb/tb_fetch_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared opcode, xop and entry definitions for the fetch queue.
// Optional predecode storage is enabled by FETCH_QUEUE_PREDECODE_EN.
package fetch_pkg;

    localparam logic [3:0] OP_SUB  = 4'h0;
    localparam logic [3:0] OP_MOVL = 4'h8;
    localparam logic [3:0] OP_MOVH = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_MEM  = 4'hF;

    localparam logic [3:0] XOP_JZ  = 4'h0;
    localparam logic [3:0] XOP_JNZ = 4'h1;
    localparam logic [3:0] XOP_JS  = 4'h2;
    localparam logic [3:0] XOP_JNS = 4'h3;
    localparam logic [3:0] XOP_LD  = 4'h0;
    localparam logic [3:0] XOP_ST  = 4'h1;

    localparam logic [15:0] NOP_INSN = 16'hE010;

    typedef struct packed {
        logic [15:0] insn;
        logic [15:0] pc;
    } fq_entry_t;

    // {is_jump, is_mem, is_illegal}
    function automatic logic [2:0] predecode(input logic [15:0] insn);
        logic [3:0] op;
        logic [3:0] xop;
        logic       is_j;
        logic       is_m;
        logic       is_ill;
        op     = insn[15:12];
        xop    = insn[7:4];
        is_j   = (op == OP_JMP);
        is_m   = (op == OP_MEM) && ((xop == XOP_LD) || (xop == XOP_ST));
        is_ill = 1'b1;
        case (op)
            OP_SUB, OP_MOVL, OP_MOVH: is_ill = 1'b0;
            OP_JMP:                   is_ill = (xop > XOP_JNS);
            OP_MEM:                   is_ill = !is_m;
            default:                  is_ill = 1'b1;
        endcase
        return {is_j, is_m, is_ill};
    endfunction

endpackage

// File: rtl/fq_fifo.sv
// Instruction FIFO: DEPTH x W storage, push/pop/flush, occupancy out.
// Push and pop together keep occupancy; pushed data is visible next cycle.
module fq_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = $bits(fq_entry_t)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [W-1:0]               i_wdata,
    input  logic                       i_pop,
    output logic [W-1:0]               o_rdata,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && !i_flush;
    assign w_pop   = i_pop && !i_flush && (r_count != '0);
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage write; contents need no reset since occupancy gates use.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy update; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The issue credit rule must never let a push land in a full queue.
    a_no_push_full: assert property (
        @(posedge clk) disable iff (rst)
        w_push |-> (r_count != FULL)
    );

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-based issue, MEM_LAT in-flight tracking,
// redirect flush, and a FIFO to decode. Option: FETCH_QUEUE_PREDECODE_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MEM_LAT  = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [14:0] mem_raddr,
    input  logic [15:0] mem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_insn,
    output logic [15:0] out_pc
`ifdef FETCH_QUEUE_PREDECODE_EN
    ,
    output logic [2:0]  out_pre
`endif
);

    localparam int AW = $clog2(DEPTH);
`ifdef FETCH_QUEUE_PREDECODE_EN
    localparam int EW = $bits(fq_entry_t) + 3;
`else
    localparam int EW = $bits(fq_entry_t);
`endif

    logic [15:0]        r_fetch_pc;
    logic [MEM_LAT-1:0] r_infl_v;
    logic [15:0]        r_infl_pc [MEM_LAT];

    logic [AW:0]   w_occ;
    logic [4:0]    w_infl_cnt;
    logic [5:0]    w_used;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    fq_entry_t     w_push_ent;
    fq_entry_t     w_head_ent;
    logic [EW-1:0] w_wdata;
    logic [EW-1:0] w_rdata;

    // Count reads still travelling through the memory pipeline.
    always_comb begin
        w_infl_cnt = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            w_infl_cnt = w_infl_cnt + 5'(r_infl_v[i]);
        end
    end

    assign w_used    = 6'(w_occ) + 6'(w_infl_cnt);
    assign w_issue   = !redirect && (w_used < 6'(DEPTH));
    assign mem_raddr = r_fetch_pc[15:1];

    assign w_push     = r_infl_v[MEM_LAT-1];
    assign out_valid  = (w_occ != '0);
    assign w_pop      = out_valid && out_ready;
    assign w_push_ent = '{insn: mem_rdata, pc: r_infl_pc[MEM_LAT-1]};

`ifdef FETCH_QUEUE_PREDECODE_EN
    assign w_wdata    = {predecode(mem_rdata), w_push_ent};
    assign w_head_ent = w_rdata[$bits(fq_entry_t)-1:0];
    assign out_pre    = w_rdata[EW-1 -: 3];
`else
    assign w_wdata    = w_push_ent;
    assign w_head_ent = w_rdata;
`endif

    assign out_insn = w_head_ent.insn;
    assign out_pc   = w_head_ent.pc;

    // Fetch PC: reset, then redirect target, else advance on each issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect) begin
            r_fetch_pc <= {redirect_pc[15:1], 1'b0};
        end else if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + 16'd2;
        end
    end

    // In-flight valid bits; a redirect kills everything already issued.
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            r_infl_v <= '0;
        end else begin
            r_infl_v[0] <= w_issue;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_infl_v[i] <= r_infl_v[i-1];
            end
        end
    end

    // In-flight PCs follow the valid bits; only qualified slots are used.
    always_ff @(posedge clk) begin
        r_infl_pc[0] <= r_fetch_pc;
        for (int i = 1; i < MEM_LAT; i++) begin
            r_infl_pc[i] <= r_infl_pc[i-1];
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (w_occ)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a MEM_LAT-cycle memory model.
// Predecode vectors run when FETCH_QUEUE_PREDECODE_EN is defined.
module tb_fetch_queue;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_insn;
    logic [15:0] out_pc;
`ifdef FETCH_QUEUE_PREDECODE_EN
    logic [2:0]  out_pre;
`endif

    logic [15:0] mem [32768];
    logic [14:0] pipe [LAT];

    int n_chk = 0;
    int n_err = 0;

    fetch_queue #(
        .DEPTH    (4),
        .MEM_LAT  (LAT),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_insn    (out_insn),
        .out_pc      (out_pc)
`ifdef FETCH_QUEUE_PREDECODE_EN
        ,
        .out_pre     (out_pre)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pipe[0] <= mem_raddr;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign mem_rdata = mem[pipe[LAT-1]];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
    endtask

    // Wait (bounded) for the head, check it, let the next edge pop it.
    task automatic next_out(input string tag, input logic [15:0] pc,
                            input logic [15:0] insn);
        int n = 0;
        while (!out_valid && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_pc"}, 32'(out_pc), 32'(pc));
            chk({tag, "_insn"}, 32'(out_insn), 32'(insn));
        end
        @(negedge clk);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 32768; i++) mem[i] = 16'(i);
        @(negedge clk);

        // Reset release and streaming
        do_reset();
        chk("first_issue", 32'(mem_raddr), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("c1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("c2_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("c3_valid", 32'(out_valid), 32'd1);
        chk("c3_pc", 32'(out_pc), 32'd0);
        chk("c3_insn", 32'(out_insn), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_pc", 32'(out_pc), 32'(2 * i));
            chk("stream_insn", 32'(out_insn), 32'(i));
        end

        // Backpressure saturation
        do_reset();
        out_ready = 1'b0;
        repeat (20) @(negedge clk);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_head", 32'(out_pc), 32'd0);
        chk("bp_issued", 32'(mem_raddr), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++)
            next_out("bp_drain", 16'(2 * i), 16'(i));

        // Redirect with data queued and reads in flight
        do_reset();
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_redir_valid", 32'(out_valid), 32'd1);
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        @(negedge clk);
        redirect = 1'b0;
        chk("post_redir_valid", 32'(out_valid), 32'd0);
        k = 0;
        while (!out_valid && k < 16) begin
            @(negedge clk);
            k++;
        end
        chk("redir_lat", 32'(k), 32'(LAT + 1));
        out_ready = 1'b1;
        next_out("redir100", 16'h0100, 16'h0080);
        next_out("redir102", 16'h0102, 16'h0081);

        // Back-to-back redirects
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        @(negedge clk);
        redirect_pc = 16'h0200;
        @(negedge clk);
        redirect = 1'b0;
        chk("b2b_valid", 32'(out_valid), 32'd0);
        next_out("b2b", 16'h0200, 16'h0100);

        // PC wrap at the top of memory, odd target bit dropped
        redirect = 1'b1;
        redirect_pc = 16'hFFFD;
        @(negedge clk);
        redirect = 1'b0;
        next_out("wrap0", 16'hFFFC, 16'h7FFE);
        next_out("wrap1", 16'hFFFE, 16'h7FFF);
        next_out("wrap2", 16'h0000, 16'h0000);

        // Reset beats a simultaneous redirect mid-operation
        rst = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0300;
        @(negedge clk);
        redirect = 1'b0;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        next_out("rst_mid", 16'h0000, 16'h0000);

`ifdef FETCH_QUEUE_PREDECODE_EN
        begin
            logic [2:0] exp_pre [4];
            mem[0] = 16'hF010;
            mem[1] = 16'hE123;
            mem[2] = 16'h8FF1;
            mem[3] = 16'h3000;
            exp_pre[0] = 3'b010;
            exp_pre[1] = 3'b100;
            exp_pre[2] = 3'b000;
            exp_pre[3] = 3'b001;
            do_reset();
            out_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                k = 0;
                while (!out_valid && k < 16) begin
                    @(negedge clk);
                    k++;
                end
                chk("pre_valid", 32'(out_valid), 32'd1);
                chk("pre_pc", 32'(out_pc), 32'(2 * i));
                chk("pre_bits", 32'(out_pre), 32'(exp_pre[i]));
                @(negedge clk);
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
